// File: rtl/s1c88_pkg.sv
// Shared S1C88 bus definitions: bus commands, decoded regions, FSM states
// and register-file offsets used by the CPU side and the bus target.
package s1c88_pkg;

   typedef enum logic [1:0] {
      BUS_IDLE      = 2'd0,
      BUS_IRQ_READ  = 2'd1,
      BUS_MEM_WRITE = 2'd2,
      BUS_MEM_READ  = 2'd3
   } bus_command_e;

   typedef enum logic [2:0] {
      RGN_NONE,
      RGN_ROM,
      RGN_RAM,
      RGN_REG,
      RGN_VEC
   } region_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_WRITE
   } state_e;

   localparam logic [7:0]  REG_IRQ_ENABLE     = 8'h00;
   localparam logic [7:0]  REG_IRQ_PENDING    = 8'h01;
   localparam logic [7:0]  REG_OPEN_BUS_COUNT = 8'h02;
   localparam logic [23:0] DUMMY_ADDR         = 24'hDEFACE;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/s1c88_bus_target_irq_latch.sv
// Interrupt latch: rising-edge capture into PENDING, ENABLE register,
// lowest-index priority select and vector generation for IRQ-read cycles.
module irq_latch
   import s1c88_pkg::*;
#(
   parameter logic [7:0] VEC_BASE = 8'h06
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] irq_lines_i,
   input  logic       enable_we_i,
   input  logic       pending_w1c_i,
   input  logic [7:0] wdata_i,
   input  logic       ack_i,
   output logic [7:0] enable_o,
   output logic [7:0] pending_o,
   output logic       irq_o,
   output logic       vec_valid_o,
   output logic [7:0] vec_o
);

   logic [7:0] enable_q, enable_d;
   logic [7:0] pending_q, pending_d;
   logic [7:0] hist_q;
   logic [7:0] rise;
   logic [7:0] active;
   logic [7:0] clr_mask;
   logic [2:0] idx;
   logic       irq_q;

   for (genvar gi = 0; gi < 8; gi++) begin : g_edge
      assign rise[gi] = irq_lines_i[gi] & ~hist_q[gi];
   end

   always_comb begin
      active = pending_q & enable_q;
      idx    = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (active[i]) idx = 3'(i);
      end
      clr_mask = pending_w1c_i ? wdata_i : 8'h00;
      if (ack_i && (active != 8'h00)) clr_mask = clr_mask | (8'd1 << idx);
      enable_d  = enable_we_i ? wdata_i : enable_q;
      // a new edge wins over a clear of the same bit
      pending_d = (pending_q & ~clr_mask) | rise;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_q  <= 8'h00;
         pending_q <= 8'h00;
         hist_q    <= 8'h00;
         irq_q     <= 1'b0;
      end else begin
         enable_q  <= enable_d;
         pending_q <= pending_d;
         hist_q    <= irq_lines_i;
         irq_q     <= |active;
      end
   end

   assign enable_o    = enable_q;
   assign pending_o   = pending_q;
   assign irq_o       = irq_q;
   assign vec_valid_o = |active;
   assign vec_o       = VEC_BASE + {4'd0, idx, 1'b0};

endmodule

// File: rtl/s1c88_bus_target.sv
// S1C88 bus target: decodes CPU accesses onto BIOS ROM, work RAM and the
// register file, and answers IRQ-read vector fetches.
module s1c88_bus_target
   import s1c88_pkg::*;
#(
   parameter int          RAM_AW   = 12,
   parameter int          ROM_AW   = 12,
   parameter logic [23:0] RAM_BASE = 24'h001000,
   parameter logic [23:0] REG_BASE = 24'h002000,
   parameter logic [7:0]  OPEN_BUS = 8'hFF,
   parameter logic [7:0]  VEC_BASE = 8'h06
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [23:0]       address_in,
   input  logic [1:0]        bus_status,
   input  logic              pk,
   input  logic              read,
   input  logic              write,
   input  logic [7:0]        data_in,
   output logic [7:0]        data_out,
   output logic [ROM_AW-1:0] rom_address,
   input  logic [7:0]        rom_data,
   input  logic [7:0]        irq_in,
   output logic              irq,
   input  logic              iack
);

   localparam logic [24:0] ROM_LIMIT = 25'd1 << ROM_AW;
   localparam logic [24:0] RAM_LIMIT = {1'b0, RAM_BASE} + (25'd1 << RAM_AW);
   localparam logic [24:0] REG_LIMIT = {1'b0, REG_BASE} + 25'd256;

   bus_command_e cmd;
   region_e      addr_rgn;
   state_e       state_q, state_d;
   region_e      region_q, region_d;
   logic [7:0]   offset_q, offset_d;
   logic [7:0]   count_q, count_d;
   logic [7:0]   hold_q;
   logic [7:0]   ram_q;
   logic         alive_q;
   logic [7:0]   ram_mem [0:(1 << RAM_AW) - 1];
   logic         read_start, wr_commit, vec_ack, count_inc;
   logic         reg_wr, ram_we;
   logic [7:0]   rd_mux, reg_rdata;
   logic [7:0]   irq_enable, irq_pending, vec;
   logic         vec_valid;
   logic         unused_inputs;

   assign cmd           = bus_command_e'(bus_status);
   assign rom_address   = address_in[ROM_AW-1:0];
   assign unused_inputs = ^{read, iack};

   always_comb begin
      addr_rgn = RGN_NONE;
      if ({1'b0, address_in} < ROM_LIMIT)
         addr_rgn = RGN_ROM;
      else if (address_in >= RAM_BASE && {1'b0, address_in} < RAM_LIMIT)
         addr_rgn = RGN_RAM;
      else if (address_in >= REG_BASE && {1'b0, address_in} < REG_LIMIT)
         addr_rgn = RGN_REG;
   end

   always_comb begin
      state_d    = state_q;
      region_d   = region_q;
      offset_d   = offset_q;
      read_start = 1'b0;
      wr_commit  = write && (cmd == BUS_MEM_WRITE) && (state_q != S_DATA);
      case (state_q)
         S_IDLE: begin
            if (!pk && (cmd == BUS_MEM_READ || cmd == BUS_IRQ_READ)) begin
               state_d    = S_DATA;
               read_start = 1'b1;
               region_d   = (cmd == BUS_IRQ_READ) ? RGN_VEC : addr_rgn;
               offset_d   = address_in[7:0];
            end else if (!pk && cmd == BUS_MEM_WRITE) begin
               state_d = S_WRITE;
            end
         end
         S_DATA:  state_d = S_IDLE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      vec_ack   = (state_q == S_DATA) && (region_q == RGN_VEC);
      // unmapped reads, unmapped writes (except the dummy address) and empty vector fetches
      count_inc = (read_start && region_d == RGN_NONE) ||
                  (wr_commit && addr_rgn == RGN_NONE && address_in != DUMMY_ADDR) ||
                  (vec_ack && !vec_valid);
      count_d   = count_inc ? sat_inc(count_q) : count_q;
   end

   assign reg_wr = wr_commit && (addr_rgn == RGN_REG);
   assign ram_we = wr_commit && (addr_rgn == RGN_RAM) && alive_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         region_q <= RGN_NONE;
         offset_q <= 8'h00;
         count_q  <= 8'h00;
         hold_q   <= OPEN_BUS;
         alive_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         region_q <= region_d;
         offset_q <= offset_d;
         count_q  <= count_d;
         alive_q  <= 1'b1;
         if (state_q == S_DATA) hold_q <= rd_mux;
      end
   end

   // alive_q blocks RAM writes while reset is asserted and on the release edge
   always_ff @(posedge clk) begin
      if (ram_we) ram_mem[address_in[RAM_AW-1:0]] <= data_in;
      if (read_start) ram_q <= ram_mem[address_in[RAM_AW-1:0]];
   end

   irq_latch #(
      .VEC_BASE (VEC_BASE)
   ) u_irq_latch (
      .clk           (clk),
      .reset         (reset),
      .irq_lines_i   (irq_in),
      .enable_we_i   (reg_wr && address_in[7:0] == REG_IRQ_ENABLE),
      .pending_w1c_i (reg_wr && address_in[7:0] == REG_IRQ_PENDING),
      .wdata_i       (data_in),
      .ack_i         (vec_ack),
      .enable_o      (irq_enable),
      .pending_o     (irq_pending),
      .irq_o         (irq),
      .vec_valid_o   (vec_valid),
      .vec_o         (vec)
   );

   always_comb begin
      case (offset_q)
         REG_IRQ_ENABLE:     reg_rdata = irq_enable;
         REG_IRQ_PENDING:    reg_rdata = irq_pending;
         REG_OPEN_BUS_COUNT: reg_rdata = count_q;
         default:            reg_rdata = 8'h00;
      endcase
      case (region_q)
         RGN_ROM: rd_mux = rom_data;
         RGN_RAM: rd_mux = ram_q;
         RGN_REG: rd_mux = reg_rdata;
         RGN_VEC: rd_mux = vec_valid ? vec : OPEN_BUS;
         default: rd_mux = OPEN_BUS;
      endcase
   end

   assign data_out = (state_q == S_DATA) ? rd_mux : hold_q;

endmodule

// File: tb/tb_s1c88_bus_target.sv
// Randomized bus-level bench for s1c88_bus_target with a transaction-level
// reference model of RAM, registers, interrupt pending state and the counter.
module tb_s1c88_bus_target;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [23:0] address_in = 24'h0;
   logic [1:0]  bus_status = 2'd0;
   logic        pk = 1'b1;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [7:0]  data_out;
   logic [11:0] rom_address;
   logic [7:0]  rom_data = 8'h00;
   logic [7:0]  irq_in = 8'h00;
   logic        irq;
   logic        iack = 1'b0;

   int vec_cnt = 0;
   int err_cnt = 0;

   bit [7:0] m_en, m_pend, m_cnt, m_prev;
   bit [7:0] m_ram [4096];
   bit       m_vld [4096];

   s1c88_bus_target dut (
      .clk         (clk),
      .reset       (reset),
      .address_in  (address_in),
      .bus_status  (bus_status),
      .pk          (pk),
      .read        (read),
      .write       (write),
      .data_in     (data_in),
      .data_out    (data_out),
      .rom_address (rom_address),
      .rom_data    (rom_data),
      .irq_in      (irq_in),
      .irq         (irq),
      .iack        (iack)
   );

   always #5 clk = ~clk;

   function automatic bit [7:0] rom_fn(input bit [11:0] a);
      if (a == 12'h123) return 8'hA5;
      return a[7:0] ^ 8'h5A ^ {4'h0, a[11:8]};
   endfunction

   always @(posedge clk) rom_data <= rom_fn(rom_address);

   function automatic int rgn_of(input bit [23:0] a);
      if (a < 24'h001000) return 1;
      if (a >= 24'h001000 && a < 24'h002000) return 2;
      if (a >= 24'h002000 && a < 24'h002100) return 3;
      return 0;
   endfunction

   function automatic bit [7:0] sat(input bit [7:0] v);
      return (v == 8'hFF) ? 8'hFF : v + 8'd1;
   endfunction

   function automatic bit [23:0] ram_pick();
      int k;
      k = $urandom_range(0, 31);
      return (k < 16) ? 24'h001000 + 24'(k) : 24'h001FF0 + 24'(k - 16);
   endfunction

   function automatic bit [23:0] unmapped_pick();
      case ($urandom_range(0, 3))
         0:       return 24'hDEFACE;
         1:       return 24'h003000 + 24'($urandom_range(0, 4095));
         2:       return 24'h002100 + 24'($urandom_range(0, 255));
         default: return 24'hFFFFFF;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_read(input string tag, input bit [1:0] cmd, input bit [23:0] addr,
                          output bit [7:0] got);
      bit [7:0] exp, act;
      bit       known;
      int       off, idx;
      known = 1'b1;
      exp   = 8'hFF;
      if (cmd == 2'd1) begin
         act = m_pend & m_en;
         if (act == 8'h00) begin
            m_cnt = sat(m_cnt);
         end else begin
            idx = 0;
            for (int i = 7; i >= 0; i--) if (act[i]) idx = i;
            exp = 8'h06 + 8'(2 * idx);
            m_pend[idx] = 1'b0;
         end
      end else begin
         case (rgn_of(addr))
            1: exp = rom_fn(addr[11:0]);
            2: begin
               off   = int'(addr - 24'h001000);
               known = m_vld[off];
               exp   = m_ram[off];
            end
            3: begin
               case (addr[7:0])
                  8'h00:   exp = m_en;
                  8'h01:   exp = m_pend;
                  8'h02:   exp = m_cnt;
                  default: exp = 8'h00;
               endcase
            end
            default: m_cnt = sat(m_cnt);
         endcase
      end
      @(negedge clk);
      address_in = addr; bus_status = cmd; pk = 1'b0; read = (cmd == 2'd3);
      @(negedge clk);
      pk  = 1'b1;
      got = data_out;
      @(negedge clk);
      bus_status = 2'd0; read = 1'b0;
      $display("rd  %-5s cmd=%0d addr=%06h data=%02h", tag, cmd, addr, got);
      if (known) check(tag, got, exp);
   endtask

   task automatic do_write(input string tag, input bit [23:0] addr, input bit [7:0] d,
                           input bit [7:0] irq_new);
      int off;
      case (rgn_of(addr))
         2: begin
            off = int'(addr - 24'h001000);
            m_ram[off] = d;
            m_vld[off] = 1'b1;
         end
         3: begin
            if (addr[7:0] == 8'h00) m_en = d;
            if (addr[7:0] == 8'h01) m_pend = m_pend & ~d;
         end
         0: if (addr != 24'hDEFACE) m_cnt = sat(m_cnt);
         default: ;
      endcase
      m_pend = m_pend | (irq_new & ~m_prev);
      m_prev = irq_new;
      @(negedge clk);
      address_in = addr; bus_status = 2'd2; pk = 1'b0; write = 1'b1;
      data_in = d; irq_in = irq_new;
      @(negedge clk);
      pk = 1'b1; write = 1'b0;
      @(negedge clk);
      bus_status = 2'd0;
      $display("wr  %-5s addr=%06h data=%02h irq_in=%02h", tag, addr, d, irq_new);
   endtask

   task automatic pulse(input bit [7:0] v);
      @(negedge clk);
      irq_in = v;
      @(negedge clk);
      m_pend = m_pend | (v & ~m_prev);
      m_prev = v;
      $display("irq irq_in=%02h", v);
   endtask

   task automatic check_irq(input string tag);
      @(negedge clk);
      check(tag, irq, 16'(|(m_pend & m_en)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [7:0]  g;
      bit [23:0] a;
      int        op;

      m_en = 0; m_pend = 0; m_cnt = 0; m_prev = 0;
      repeat (3) @(negedge clk);
      check("rst_dout", data_out, 16'hFF);
      check("rst_irq", irq, 16'h0);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_rel_dout", data_out, 16'hFF);

      // ROM read with 1-cycle synchronous ROM
      do_read("rom", 2'd3, 24'h000123, g);
      check("rom_a5", g, 16'hA5);
      check("rom_addr", rom_address, 16'h123);
      check("hold", data_out, 16'hA5);

      // RAM round trip at the last byte, plus an unmapped write
      do_write("ram", 24'h001FFF, 8'h3C, m_prev);
      do_read("ram", 2'd3, 24'h001FFF, g);
      check("ram_rt", g, 16'h3C);
      do_write("unm", 24'h002FFF, 8'h55, m_prev);
      do_read("ram", 2'd3, 24'h001FFF, g);
      do_read("obc", 2'd3, 24'h002002, g);
      check("obc_one", g, 16'h01);
      do_read("deface", 2'd3, 24'hDEFACE, g);
      do_write("deface", 24'hDEFACE, 8'h11, m_prev);
      do_read("obc", 2'd3, 24'h002002, g);
      check("obc_two", g, 16'h02);

      // interrupt priority
      do_write("ien", 24'h002000, 8'hFF, m_prev);
      pulse(8'h24);
      check_irq("irq_up");
      do_read("vec", 2'd1, 24'h000000, g);
      check("vec_2", g, 16'h0A);
      do_read("pend", 2'd3, 24'h002001, g);
      check("pend_20", g, 16'h20);
      do_read("vec", 2'd1, 24'h000000, g);
      check("vec_5", g, 16'h10);
      check_irq("irq_down");
      do_read("vec", 2'd1, 24'h000000, g);
      pulse(8'h00);

      // W1C against a simultaneous new edge on the same bit
      pulse(8'h08);
      pulse(8'h00);
      do_write("w1c", 24'h002001, 8'h08, 8'h08);
      do_read("pend", 2'd3, 24'h002001, g);
      check("w1c_coll", g & 8'h08, 16'h08);
      pulse(8'h00);

      for (int k = 0; k < 16; k++) begin
         do_write("init", 24'h001000 + 24'(k), 8'($urandom), m_prev);
         do_write("init", 24'h001FF0 + 24'(k), 8'($urandom), m_prev);
      end

      for (int n = 0; n < 250; n++) begin
         op = $urandom_range(0, 9);
         case (op)
            0: do_read("rom", 2'd3, 24'($urandom_range(0, 4095)), g);
            1: begin a = ram_pick(); do_read("ram", 2'd3, a, g); end
            2: begin a = ram_pick(); do_write("ram", a, 8'($urandom), m_prev); end
            3: do_read("reg", 2'd3, 24'h002000 + 24'($urandom_range(0, 4)), g);
            4: do_write("reg", 24'h002000 + 24'($urandom_range(0, 3)), 8'($urandom),
                        ($urandom_range(0, 2) == 0) ? 8'($urandom) : m_prev);
            5: begin a = unmapped_pick(); do_read("unm", 2'd3, a, g); end
            6: begin a = unmapped_pick(); do_write("unm", a, 8'($urandom), m_prev); end
            7: do_read("vec", 2'd1, 24'($urandom), g);
            8: pulse(8'($urandom));
            default: do_write("rom", 24'($urandom_range(0, 4095)), 8'($urandom), m_prev);
         endcase
         check_irq("irq_rand");
      end

      // counter saturation
      for (int n = 0; n < 300; n++) begin
         a = unmapped_pick();
         do_read("unm", 2'd3, a, g);
      end
      do_read("obc", 2'd3, 24'h002002, g);
      check("obc_sat", g, 16'hFF);

      // asynchronous reset in the middle of a read
      do_write("ien", 24'h002000, 8'hFF, m_prev);
      pulse(8'h00);
      pulse(8'h01);
      check_irq("irq_pre_rst");
      @(negedge clk);
      address_in = 24'h001FFF; bus_status = 2'd3; pk = 1'b0; read = 1'b1;
      @(negedge clk);
      pk = 1'b1;
      #2;
      reset = 1'b0;
      irq_in = 8'h00;
      #1;
      check("arst_dout", data_out, 16'hFF);
      check("arst_irq", irq, 16'h0);
      @(negedge clk);
      bus_status = 2'd0; read = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_en = 0; m_pend = 0; m_cnt = 0; m_prev = 0;
      repeat (2) @(negedge clk);
      do_read("reg", 2'd3, 24'h002000, g);
      do_read("reg", 2'd3, 24'h002001, g);
      do_read("reg", 2'd3, 24'h002002, g);
      check("arst_cnt", g, 16'h00);
      do_read("ram", 2'd3, 24'h001FFF, g);
      check_irq("irq_post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/s1c88_bus_target.md
Name: s1c88_bus_target

Overview:
- Memory-side responder for the S1C88 CPU bus.
- Decodes the CPU's address, bus_status, read, write and pk signals, and serves reads from an external BIOS ROM, internal work RAM, and a small register file.
- Commits CPU writes to RAM and registers.
- Contains the interrupt latch/prioritiser that answers IRQ-read (vector fetch) cycles.
- Sits between the CPU core and the rest of the system map, as the only target on the CPU bus.

Parameters:
- RAM_AW, 12, work-RAM address width (4 KiB).
- ROM_AW, 12, BIOS ROM address width (4 KiB).
- RAM_BASE, 24'h001000, first RAM byte address.
- REG_BASE, 24'h002000, first register address; registers occupy 256 bytes.
- OPEN_BUS, 8'hFF, value returned for unmapped reads.
- VEC_BASE, 8'h06, vector byte returned for IRQ line 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- address_in  in  24  CPU address; stable from the CPU negedge before the access.
- bus_status  in  2  0 IDLE, 1 IRQ_READ, 2 MEM_WRITE, 3 MEM_READ.
- pk  in  1  CPU phase; pk==0 at a posedge marks the access-start edge.
- read  in  1  CPU read strobe; informational only, for assertion checking.
- write  in  1  CPU write strobe.
- data_in  in  8  CPU write data.
- data_out  out  8  read data to the CPU.
- rom_address  out  ROM_AW  BIOS ROM address; combinational from address_in.
- rom_data  in  8  ROM data; synchronous ROM with 1-cycle latency.
- irq_in  in  8  peripheral interrupt lines; level inputs, rising-edge sensitive.
- irq  out  1  interrupt request to the CPU.
- iack  in  1  CPU acknowledge flag; held high through exception processing.

Behaviour:
- Reset values (reset low): data_out=OPEN_BUS, irq=0, FSM=S_IDLE, IRQ_ENABLE=0, IRQ_PENDING=0, OPEN_BUS_COUNT=0, irq_in edge-history=0. RAM contents are not reset.
- Region decode, all 24 address bits compared:
  - ROM: address < 2^ROM_AW.
  - RAM: RAM_BASE .. RAM_BASE+2^RAM_AW-1.
  - REG: REG_BASE .. REG_BASE+255.
  - Anything else is unmapped.
- FSM states: S_IDLE, S_DATA, S_WRITE.
  - S_IDLE→S_DATA: posedge with pk==0 and bus_status in {MEM_READ, IRQ_READ}. On that edge:
    - latch the region and the low 8 address bits;
    - issue the RAM read;
    - ROM is already addressed.
  - S_IDLE→S_WRITE: posedge with pk==0 and bus_status==MEM_WRITE.
  - S_DATA→S_IDLE and S_WRITE→S_IDLE: unconditional next edge.
- Read latency:
  - data_out is valid throughout the S_DATA cycle, so the CPU samples it at the pk==1 posedge.
  - data_out is a mux on the latched region: ROM→rom_data, RAM→RAM q, REG→register value, unmapped→OPEN_BUS.
  - data_out holds its last value when not in S_DATA.
- Writes:
  - Commit on a posedge with write==1 and bus_status==MEM_WRITE, in either S_IDLE or S_WRITE; one commit per strobe cycle.
  - ROM writes are silently dropped.
  - Unmapped writes are dropped and counted.
- Registers (offset from REG_BASE):
  - 0x00 IRQ_ENABLE: RW.
  - 0x01 IRQ_PENDING: read; write-1-to-clear.
  - 0x02 OPEN_BUS_COUNT: RO; saturating 8-bit count of unmapped reads and writes, saturates at 0xFF.
  - All other offsets read 0x00 and ignore writes.
- Interrupts:
  - A rising edge on irq_in[i] (compared against a registered copy) sets IRQ_PENDING[i].
  - irq = |(IRQ_PENDING & IRQ_ENABLE), registered (1-cycle latency from pending).
- IRQ_READ cycle:
  - Selects the lowest i with PENDING&ENABLE set.
  - data_out = VEC_BASE + 2*i.
  - Clears PENDING[i] on the S_DATA edge.
  - With none pending, it returns OPEN_BUS and counts the access.
- Simultaneous events: a set (edge) and a clear (W1C write or ack) of the same bit on the same edge resolve to set.
- Reset mid-access: asynchronous return to reset values; no partial RAM write occurs on that edge.
- bus_status==IDLE or the 24'hDEFACE dummy address never alters state, except that a DEFACE read counts as unmapped.

Decomposition:
- Shared package s1c88_pkg:
  - BusCommand enum (IDLE/IRQ_READ/MEM_WRITE/MEM_READ, 2-bit), also used by the CPU;
  - region enum;
  - register offset constants.
- Sub-module irq_latch: edge detect, pending/enable registers, priority encoder, vector output.

Test Plan:
- ROM read: rom_data model returns 8'hA5 at 0x000123; MEM_READ at 24'h000123 → data_out==8'hA5 at the pk==1 posedge, rom_address==12'h123.
- RAM round trip: MEM_WRITE 8'h3C to 24'h001FFF (last byte), then MEM_READ same address → 8'h3C; a write to 24'h002FFF leaves RAM unchanged and OPEN_BUS_COUNT==1.
- Unmapped: MEM_READ 24'hDEFACE → 8'hFF, counter increments; 300 unmapped reads → counter saturates at 8'hFF.
- IRQ priority: ENABLE=8'hFF, rising edges on irq_in[5] and irq_in[2] → irq==1; IRQ_READ → 8'h0A, PENDING==8'h20; second IRQ_READ → 8'h10, irq drops to 0.
- W1C collision: PENDING[3]=1; write 8'h08 to REG_BASE+1 on the same edge as a new irq_in[3] rise → PENDING[3] stays 1.
- Async reset during S_DATA: drive reset low mid-read → data_out==8'hFF, irq==0, all registers 0 without a clock edge.
